// File: rtl/stage_ma_pkg.sv
// Shared definitions for the memory-access stage: control-bit indices,
// field widths and the request FSM state type.
package stage_ma_pkg;

  localparam int CNTRL_W     = 5;
  localparam int WB_CNTRL_W  = 3;
  localparam int WB_R_WE     = 0;
  localparam int WB_MUX_LO   = 1;
  localparam int WB_MUX_HI   = 2;
  localparam int MA_MEM_RD   = 3;
  localparam int MA_MEM_WR   = 4;

  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_WAIT = 1'b1
  } ma_state_e;

  // A valid instruction needs the data memory if it reads or writes.
  function automatic logic is_mem_op(input logic valid, input logic [CNTRL_W-1:0] cntrl);
    return valid && (cntrl[MA_MEM_RD] || cntrl[MA_MEM_WR]);
  endfunction

endpackage

// File: rtl/ma_wb_reg.sv
// MA/WB pipeline register. A bubble load clears every field so the
// write-back stage sees reg_write=0 on cycles the memory stage is stalled.
module ma_wb_reg
  import stage_ma_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RDST_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_bubble,
  input  logic [WIDTH-1:0]      i_pc,
  input  logic [WIDTH-1:0]      i_data_o_ma,
  input  logic [WIDTH-1:0]      i_alu_rslt,
  input  logic [WB_CNTRL_W-1:0] i_cntrl,
  input  logic [RDST_W-1:0]     i_rdst,
  output logic [WIDTH-1:0]      o_pc,
  output logic [WIDTH-1:0]      o_data_o_ma,
  output logic [WIDTH-1:0]      o_alu_rslt,
  output logic [WB_CNTRL_W-1:0] o_cntrl,
  output logic [RDST_W-1:0]     o_rdst
);

  logic [WIDTH-1:0]      pc_q,       pc_d;
  logic [WIDTH-1:0]      data_q,     data_d;
  logic [WIDTH-1:0]      alu_rslt_q, alu_rslt_d;
  logic [WB_CNTRL_W-1:0] cntrl_q,    cntrl_d;
  logic [RDST_W-1:0]     rdst_q,     rdst_d;

  always_comb begin
    pc_d       = i_pc;
    data_d     = i_data_o_ma;
    alu_rslt_d = i_alu_rslt;
    cntrl_d    = i_cntrl;
    rdst_d     = i_rdst;
    if (i_bubble) begin
      pc_d       = '0;
      data_d     = '0;
      alu_rslt_d = '0;
      cntrl_d    = '0;
      rdst_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      data_q     <= '0;
      alu_rslt_q <= '0;
      cntrl_q    <= '0;
      rdst_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      data_q     <= data_d;
      alu_rslt_q <= alu_rslt_d;
      cntrl_q    <= cntrl_d;
      rdst_q     <= rdst_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_data_o_ma = data_q;
  assign o_alu_rslt  = alu_rslt_q;
  assign o_cntrl     = cntrl_q;
  assign o_rdst      = rdst_q;

endmodule

// File: rtl/stage_ma.sv
// Memory-access stage: drives the data-memory req/ack handshake, stalls
// upstream while a request is outstanding, and owns the MA/WB register.
module stage_ma
  import stage_ma_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RDST_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ma_valid,
  input  logic [WIDTH-1:0]      i_ma_pc,
  input  logic [WIDTH-1:0]      i_ma_alu_rslt,
  input  logic [WIDTH-1:0]      i_ma_st_data,
  input  logic [CNTRL_W-1:0]    i_ma_cntrl,
  input  logic [RDST_W-1:0]     i_ma_rdst,
  output logic                  o_ma_stall,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [WIDTH-1:0]      o_dmem_addr,
  output logic [WIDTH-1:0]      o_dmem_wdata,
  input  logic                  i_dmem_ack,
  input  logic [WIDTH-1:0]      i_dmem_rdata,
  output logic [WIDTH-1:0]      o_wb_pc,
  output logic [WIDTH-1:0]      o_wb_data_o_ma,
  output logic [WIDTH-1:0]      o_wb_alu_rslt,
  output logic [WB_CNTRL_W-1:0] o_wb_cntrl,
  output logic [RDST_W-1:0]     o_wb_rdst
);

  ma_state_e             state_q, state_d;
  logic                  mem_op;
  logic                  rd_ack;
  logic [WIDTH-1:0]      wb_data_d;
  logic [WB_CNTRL_W-1:0] wb_cntrl_d;

  always_comb begin
    mem_op       = is_mem_op(i_ma_valid, i_ma_cntrl);
    // In WAIT the EX/MA inputs are frozen by our own stall, so they still
    // describe the outstanding access; read+write together counts as a write.
    o_dmem_req   = (state_q == MA_WAIT) || mem_op;
    o_dmem_we    = o_dmem_req && i_ma_cntrl[MA_MEM_WR];
    o_dmem_addr  = i_ma_alu_rslt;
    o_dmem_wdata = i_ma_st_data;
    o_ma_stall   = o_dmem_req && !i_dmem_ack;

    state_d = state_q;
    case (state_q)
      MA_IDLE: if (mem_op && !i_dmem_ack) state_d = MA_WAIT;
      MA_WAIT: if (i_dmem_ack)            state_d = MA_IDLE;
      default:                            state_d = MA_IDLE;
    endcase

    rd_ack     = o_dmem_req && !o_dmem_we && i_dmem_ack;
    wb_data_d  = rd_ack ? i_dmem_rdata : '0;
    wb_cntrl_d = i_ma_valid ? i_ma_cntrl[WB_CNTRL_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= MA_IDLE;
    else     state_q <= state_d;
  end

  ma_wb_reg #(
    .WIDTH  (WIDTH),
    .RDST_W (RDST_W)
  ) u_ma_wb_reg (
    .clk         (clk),
    .rst         (rst),
    .i_bubble    (o_ma_stall),
    .i_pc        (i_ma_pc),
    .i_data_o_ma (wb_data_d),
    .i_alu_rslt  (i_ma_alu_rslt),
    .i_cntrl     (wb_cntrl_d),
    .i_rdst      (i_ma_rdst),
    .o_pc        (o_wb_pc),
    .o_data_o_ma (o_wb_data_o_ma),
    .o_alu_rslt  (o_wb_alu_rslt),
    .o_cntrl     (o_wb_cntrl),
    .o_rdst      (o_wb_rdst)
  );

endmodule

// File: tb/tb_stage_ma.sv
// Directed bench for stage_ma: inputs change just after the rising edge,
// combinational outputs are sampled on the falling edge, registered ones after the next rise.
module tb_stage_ma;

  logic        clk;
  logic        rst;
  logic        i_ma_valid;
  logic [31:0] i_ma_pc, i_ma_alu_rslt, i_ma_st_data;
  logic [4:0]  i_ma_cntrl;
  logic [4:0]  i_ma_rdst;
  logic        o_ma_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_wb_pc, o_wb_data_o_ma, o_wb_alu_rslt;
  logic [2:0]  o_wb_cntrl;
  logic [4:0]  o_wb_rdst;

  int checks_total  = 0;
  int checks_passed = 0;

  stage_ma #(.WIDTH(32), .RDST_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_ma_valid     (i_ma_valid),
    .i_ma_pc        (i_ma_pc),
    .i_ma_alu_rslt  (i_ma_alu_rslt),
    .i_ma_st_data   (i_ma_st_data),
    .i_ma_cntrl     (i_ma_cntrl),
    .i_ma_rdst      (i_ma_rdst),
    .o_ma_stall     (o_ma_stall),
    .o_dmem_req     (o_dmem_req),
    .o_dmem_we      (o_dmem_we),
    .o_dmem_addr    (o_dmem_addr),
    .o_dmem_wdata   (o_dmem_wdata),
    .i_dmem_ack     (i_dmem_ack),
    .i_dmem_rdata   (i_dmem_rdata),
    .o_wb_pc        (o_wb_pc),
    .o_wb_data_o_ma (o_wb_data_o_ma),
    .o_wb_alu_rslt  (o_wb_alu_rslt),
    .o_wb_cntrl     (o_wb_cntrl),
    .o_wb_rdst      (o_wb_rdst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic valid, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] st, input logic [4:0] cntrl, input logic [4:0] rdst,
                       input logic ack, input logic [31:0] rdata);
    i_ma_valid    = valid;
    i_ma_pc       = pc;
    i_ma_alu_rslt = alu;
    i_ma_st_data  = st;
    i_ma_cntrl    = cntrl;
    i_ma_rdst     = rdst;
    i_dmem_ack    = ack;
    i_dmem_rdata  = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'b0, 5'd0, 1'b0, 32'h0);
    tick();
    tick();
    check("rst_wb_cntrl", 32'(o_wb_cntrl), 32'h0);
    check("rst_wb_pc",    o_wb_pc,         32'h0);
    check("rst_req",      32'(o_dmem_req), 32'h0);
    check("rst_stall",    32'(o_ma_stall), 32'h0);
    rst = 1'b0;

    // 1: ALU op
    drive(1'b1, 32'h4, 32'h10, 32'h0, 5'b00101, 5'd7, 1'b0, 32'h0);
    @(negedge clk);
    check("alu_req",   32'(o_dmem_req), 32'h0);
    check("alu_stall", 32'(o_ma_stall), 32'h0);
    tick();
    check("alu_wb_alu",   o_wb_alu_rslt,   32'h10);
    check("alu_wb_cntrl", 32'(o_wb_cntrl), 32'h5);
    check("alu_wb_rdst",  32'(o_wb_rdst),  32'h7);
    check("alu_wb_pc",    o_wb_pc,         32'h4);

    // 2: zero-wait load
    drive(1'b1, 32'h8, 32'h100, 32'h0, 5'b01011, 5'd3, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    check("ld0_req",   32'(o_dmem_req), 32'h1);
    check("ld0_we",    32'(o_dmem_we),  32'h0);
    check("ld0_addr",  o_dmem_addr,     32'h100);
    check("ld0_stall", 32'(o_ma_stall), 32'h0);
    tick();
    check("ld0_wb_data",  o_wb_data_o_ma,  32'hDEADBEEF);
    check("ld0_wb_cntrl", 32'(o_wb_cntrl), 32'h3);

    // 3: load with three wait cycles
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'hC, 32'h200, 32'h0, 5'b01011, 5'd9, (c == 3), (c == 3) ? 32'h12345678 : 32'hFFFFFFFF);
      @(negedge clk);
      check($sformatf("ld3_stall_c%0d", c), 32'(o_ma_stall), (c == 3) ? 32'h0 : 32'h1);
      check($sformatf("ld3_addr_c%0d", c),  o_dmem_addr,     32'h200);
      check($sformatf("ld3_req_c%0d", c),   32'(o_dmem_req), 32'h1);
      tick();
      if (c < 3) check($sformatf("ld3_bubble_c%0d", c), 32'(o_wb_cntrl), 32'h0);
    end
    check("ld3_wb_data",  o_wb_data_o_ma,  32'h12345678);
    check("ld3_wb_cntrl", 32'(o_wb_cntrl), 32'h3);
    check("ld3_wb_rdst",  32'(o_wb_rdst),  32'h9);
    drive(1'b0, 32'h10, 32'h0, 32'h0, 5'b00000, 5'd0, 1'b0, 32'h0);
    tick();
    check("ld3_once_data",  o_wb_data_o_ma,  32'h0);
    check("ld3_once_cntrl", 32'(o_wb_cntrl), 32'h0);

    // 4: store, ack after one cycle
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 32'h14, 32'h40, 32'hCAFE, 5'b10110, 5'd0, (c == 1), 32'h0);
      @(negedge clk);
      check($sformatf("st_we_c%0d", c),    32'(o_dmem_we),  32'h1);
      check($sformatf("st_wdata_c%0d", c), o_dmem_wdata,    32'hCAFE);
      check($sformatf("st_addr_c%0d", c),  o_dmem_addr,     32'h40);
      check($sformatf("st_stall_c%0d", c), 32'(o_ma_stall), (c == 0) ? 32'h1 : 32'h0);
      tick();
    end
    check("st_wb_cntrl", 32'(o_wb_cntrl), 32'h6);
    check("st_wb_data",  o_wb_data_o_ma,  32'h0);
    check("st_wb_alu",   o_wb_alu_rslt,   32'h40);

    // 5: reset while waiting on a load
    drive(1'b1, 32'h18, 32'h300, 32'h0, 5'b01011, 5'd4, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'b00000, 5'd0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'b00000, 5'd0, 1'b1, 32'h00000BAD);
    @(negedge clk);
    check("rstw_req",      32'(o_dmem_req), 32'h0);
    check("rstw_stall",    32'(o_ma_stall), 32'h0);
    check("rstw_wb_cntrl", 32'(o_wb_cntrl), 32'h0);
    tick();
    check("rstw_late_data",  o_wb_data_o_ma,  32'h0);
    check("rstw_late_cntrl", 32'(o_wb_cntrl), 32'h0);

    // invalid instruction with memory bits set: no request, bubble
    drive(1'b0, 32'h1C, 32'h50, 32'h0, 5'b11111, 5'd2, 1'b0, 32'h0);
    @(negedge clk);
    check("inv_req", 32'(o_dmem_req), 32'h0);
    tick();
    check("inv_wb_cntrl", 32'(o_wb_cntrl), 32'h0);

    // read and write both set: treated as write, no load data
    drive(1'b1, 32'h20, 32'h60, 32'h77, 5'b11001, 5'd1, 1'b1, 32'h55);
    @(negedge clk);
    check("rw_we", 32'(o_dmem_we), 32'h1);
    tick();
    check("rw_wb_data",  o_wb_data_o_ma,  32'h0);
    check("rw_wb_cntrl", 32'(o_wb_cntrl), 32'h1);

    // 6: back-to-back load then ALU op
    drive(1'b1, 32'h24, 32'h104, 32'h0, 5'b01011, 5'd5, 1'b1, 32'hA5A5A5A5);
    tick();
    check("b2b_ld_data",  o_wb_data_o_ma,  32'hA5A5A5A5);
    check("b2b_ld_pc",    o_wb_pc,         32'h24);
    drive(1'b1, 32'h28, 32'h77, 32'h0, 5'b00101, 5'd6, 1'b0, 32'h0);
    tick();
    check("b2b_alu_rslt",  o_wb_alu_rslt,   32'h77);
    check("b2b_alu_cntrl", 32'(o_wb_cntrl), 32'h5);
    check("b2b_alu_data",  o_wb_data_o_ma,  32'h0);
    check("b2b_alu_pc",    o_wb_pc,         32'h28);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
